// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: parametrised register file with two combinational read
// ports, one synchronous write port and a per-register busy scoreboard.
// Issue logic reserves a destination register; the later write-back to that
// register releases it. Optional register 0 hardwired to zero (ZERO_REG).
// Optional feature macro: RF_BYPASS_EN enables write-through forwarding of
// the write-back port onto the read ports in the same cycle.
module regfile_scoreboard #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we3,
  input  logic [ADDR_W-1:0]     wa3,
  input  logic [DATA_W-1:0]     wd3,
  input  logic [ADDR_W-1:0]     ra1,
  input  logic [ADDR_W-1:0]     ra2,
  output logic [DATA_W-1:0]     rd1,
  output logic [DATA_W-1:0]     rd2,
  output logic                  busy1,
  output logic                  busy2,
  input  logic                  rsv_valid,
  input  logic [ADDR_W-1:0]     rsv_addr,
  output logic                  rsv_ready,
  output logic [ADDR_W:0]       pending,
  output logic [(1<<ADDR_W)-1:0] busy_vec
);

  localparam int NREGS = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  busy;
  logic              wr_zero;
  logic              rsv_zero;
  logic              wr_en;
  logic              rsv_acc;

  // Accesses to register 0 are swallowed when it is the hardwired zero register.
  assign wr_zero  = (ZERO_REG != 0) && (wa3 == '0);
  assign rsv_zero = (ZERO_REG != 0) && (rsv_addr == '0);
  assign wr_en    = we3 && !wr_zero;

  // A reservation can go ahead if the register is free or is being released
  // by write-back this very cycle; it never looks at rsv_valid.
  assign rsv_ready = rsv_zero || !busy[rsv_addr] || (we3 && (wa3 == rsv_addr));
  assign rsv_acc   = rsv_valid && rsv_ready && !rsv_zero;

  assign busy_vec = busy;

  // Register array: synchronous clear, then write-back of wd3 into wa3.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[wa3] <= wd3;
    end
  end

  // Scoreboard: write-back releases, reservation sets; the later assignment
  // lets a new producer win over a same-cycle release of the same register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy <= '0;
    end else begin
      if (wr_en) begin
        busy[wa3] <= 1'b0;
      end
      if (rsv_acc) begin
        busy[rsv_addr] <= 1'b1;
      end
    end
  end

  // Pending count is the population count of the scoreboard, so it can never
  // drift from busy_vec, exceed NREGS or wrap.
  always_comb begin
    pending = '0;
    for (int i = 0; i < NREGS; i++) begin
      pending = pending + (ADDR_W+1)'(busy[i]);
    end
  end

  // Read port 1: registered state, optionally overridden by the write-back.
  always_comb begin
    rd1   = ((ZERO_REG != 0) && (ra1 == '0)) ? '0 : regs[ra1];
    busy1 = busy[ra1];
`ifdef RF_BYPASS_EN
    if (wr_en && (wa3 == ra1)) begin
      rd1   = wd3;
      busy1 = rsv_acc && (rsv_addr == ra1);
    end
`endif
  end

  // Read port 2: same structure as port 1.
  always_comb begin
    rd2   = ((ZERO_REG != 0) && (ra2 == '0)) ? '0 : regs[ra2];
    busy2 = busy[ra2];
`ifdef RF_BYPASS_EN
    if (wr_en && (wa3 == ra2)) begin
      rd2   = wd3;
      busy2 = rsv_acc && (rsv_addr == ra2);
    end
`endif
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed scenarios plus randomized traffic against
// an array-based reference model of the register file and scoreboard.
module tb_regfile_scoreboard;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int NR = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          we3 = 1'b0;
  logic [AW-1:0] wa3 = '0;
  logic [DW-1:0] wd3 = '0;
  logic [AW-1:0] ra1 = '0;
  logic [AW-1:0] ra2 = '0;
  logic [DW-1:0] rd1;
  logic [DW-1:0] rd2;
  logic          busy1;
  logic          busy2;
  logic          rsv_valid = 1'b0;
  logic [AW-1:0] rsv_addr = '0;
  logic          rsv_ready;
  logic [AW:0]   pending;
  logic [NR-1:0] busy_vec;

  int n_cmp = 0;
  int n_fail = 0;

  logic [DW-1:0] m_reg [NR];
  bit            m_busy [NR];

  always #5 clk = ~clk;

  regfile_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .we3(we3), .wa3(wa3), .wd3(wd3),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2), .busy1(busy1), .busy2(busy2),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ready(rsv_ready),
    .pending(pending), .busy_vec(busy_vec)
  );

  // Reference model: rules of the register file expressed over plain arrays.
  function automatic bit m_ready();
    if (rsv_addr == 0) return 1'b1;
    return !m_busy[rsv_addr] || (we3 && wa3 == rsv_addr);
  endfunction

  function automatic logic [DW-1:0] m_rd(input logic [AW-1:0] a);
    if (a == 0) return '0;
`ifdef RF_BYPASS_EN
    if (we3 && wa3 == a) return wd3;
`endif
    return m_reg[a];
  endfunction

  function automatic logic m_bsy(input logic [AW-1:0] a);
    if (a == 0) return 1'b0;
`ifdef RF_BYPASS_EN
    if (we3 && wa3 == a) return rsv_valid && rsv_addr == a;
`endif
    return m_busy[a];
  endfunction

  function automatic logic [NR-1:0] m_vec();
    logic [NR-1:0] v = '0;
    for (int i = 0; i < NR; i++) v[i] = m_busy[i];
    return v;
  endfunction

  function automatic int m_pend();
    int c = 0;
    for (int i = 0; i < NR; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  // Advance one clock and apply the same edge to the model.
  task automatic tick();
    bit acc;
    acc = m_ready();
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < NR; i++) begin m_reg[i] = '0; m_busy[i] = 0; end
    end else begin
      if (we3 && wa3 != 0) begin m_reg[wa3] = wd3; m_busy[wa3] = 0; end
      if (rsv_valid && acc && rsv_addr != 0) m_busy[rsv_addr] = 1;
    end
    #1;
  endtask

  task automatic idle();
    we3 = 0; rsv_valid = 0;
  endtask

  task automatic test_reset();
    ra1 = 3'd1; ra2 = 3'd6; #1;
    n_cmp++; if (rd1 !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_rd1: got %h want 00", rd1); end
    n_cmp++; if (busy_vec !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_busy_vec: got %h want 00", busy_vec); end
    n_cmp++; if (pending !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_pending: got %0d want 0", pending); end
    n_cmp++; if (busy1 !== 1'b0 || busy2 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy12: got %b%b want 00", busy1, busy2); end
    for (int i = 1; i < NR; i++) begin
      we3 = 1; wa3 = AW'(i); wd3 = DW'(8'h10 + i); tick();
    end
    idle(); rsv_valid = 1; rsv_addr = 3'd3; tick(); idle();
    rst = 0; we3 = 1; wa3 = 3'd2; wd3 = 8'hEE; rsv_valid = 1; rsv_addr = 3'd4; ra1 = 3'd5; #1;
    n_cmp++; if (rd1 !== 8'h15) begin n_fail++; $display("[TB] FAIL reset_noedge_rd1: got %h want 15", rd1); end
    n_cmp++; if (pending !== 4'd1) begin n_fail++; $display("[TB] FAIL reset_noedge_pending: got %0d want 1", pending); end
    tick(); idle(); rst = 1; #1;
    n_cmp++; if (rd1 !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_rd1_after: got %h want 00", rd1); end
    ra1 = 3'd2; #1;
    n_cmp++; if (rd1 !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_priority_rd1: got %h want 00", rd1); end
    n_cmp++; if (busy_vec !== 8'h00 || pending !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_sb_after: got %h/%0d want 00/0", busy_vec, pending); end
  endtask

  task automatic test_basic();
    we3 = 1; wa3 = 3'd3; wd3 = 8'hA5; ra1 = 3'd3; ra2 = 3'd3; #1;
    n_cmp++; if (rd1 !== m_rd(3'd3)) begin n_fail++; $display("[TB] FAIL basic_pre_rd1: got %h want %h", rd1, m_rd(3'd3)); end
    tick(); idle(); #1;
    n_cmp++; if (rd1 !== 8'hA5) begin n_fail++; $display("[TB] FAIL basic_rd1: got %h want A5", rd1); end
    n_cmp++; if (rd2 !== 8'hA5) begin n_fail++; $display("[TB] FAIL basic_same_addr_rd2: got %h want A5", rd2); end
    we3 = 1; wa3 = 3'd0; wd3 = 8'hFF; ra1 = 3'd0; tick(); idle(); #1;
    n_cmp++; if (rd1 !== 8'h00) begin n_fail++; $display("[TB] FAIL basic_zero_reg: got %h want 00", rd1); end
  endtask

  task automatic test_scoreboard();
    rsv_valid = 1; rsv_addr = 3'd5; #1;
    n_cmp++; if (rsv_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL sb_ready_free: got %b want 1", rsv_ready); end
    tick(); idle(); ra1 = 3'd5; #1;
    n_cmp++; if (busy_vec !== 8'h20) begin n_fail++; $display("[TB] FAIL sb_busy_vec: got %h want 20", busy_vec); end
    n_cmp++; if (pending !== 4'd1) begin n_fail++; $display("[TB] FAIL sb_pending: got %0d want 1", pending); end
    n_cmp++; if (rsv_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL sb_ready_busy: got %b want 0", rsv_ready); end
    n_cmp++; if (busy1 !== 1'b1) begin n_fail++; $display("[TB] FAIL sb_busy1: got %b want 1", busy1); end
    we3 = 1; wa3 = 3'd5; wd3 = 8'h5A; tick(); idle(); #1;
    n_cmp++; if (busy_vec !== 8'h00 || pending !== 4'd0) begin n_fail++; $display("[TB] FAIL sb_release: got %h/%0d want 00/0", busy_vec, pending); end
    n_cmp++; if (rd1 !== 8'h5A) begin n_fail++; $display("[TB] FAIL sb_write_rd1: got %h want 5A", rd1); end
  endtask

  task automatic test_simultaneous();
    rsv_valid = 1; rsv_addr = 3'd5; tick(); idle();
    we3 = 1; wa3 = 3'd5; wd3 = 8'hC3; rsv_valid = 1; rsv_addr = 3'd5; ra1 = 3'd5; #1;
    n_cmp++; if (rsv_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL sim_ready: got %b want 1", rsv_ready); end
    n_cmp++; if (busy1 !== m_bsy(3'd5) || rd1 !== m_rd(3'd5)) begin n_fail++; $display("[TB] FAIL sim_pre_read: got %b/%h want %b/%h", busy1, rd1, m_bsy(3'd5), m_rd(3'd5)); end
    tick(); idle(); #1;
    n_cmp++; if (rd1 !== 8'hC3) begin n_fail++; $display("[TB] FAIL sim_rd1: got %h want C3", rd1); end
    n_cmp++; if (busy_vec !== 8'h20 || pending !== 4'd1) begin n_fail++; $display("[TB] FAIL sim_same_sb: got %h/%0d want 20/1", busy_vec, pending); end
    we3 = 1; wa3 = 3'd5; wd3 = 8'h11; rsv_valid = 1; rsv_addr = 3'd6; tick(); idle(); #1;
    n_cmp++; if (busy_vec !== 8'h40 || pending !== 4'd1) begin n_fail++; $display("[TB] FAIL sim_diff_sb: got %h/%0d want 40/1", busy_vec, pending); end
    we3 = 1; wa3 = 3'd6; wd3 = 8'h66; tick(); idle();
  endtask

  task automatic test_fill();
    for (int i = 1; i < NR; i++) begin
      rsv_valid = 1; rsv_addr = AW'(i); tick();
    end
    idle(); #1;
    n_cmp++; if (pending !== 4'd7 || busy_vec !== 8'hFE) begin n_fail++; $display("[TB] FAIL fill_full: got %0d/%h want 7/FE", pending, busy_vec); end
    rsv_valid = 1; rsv_addr = 3'd0; #1;
    n_cmp++; if (rsv_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL fill_ready_r0: got %b want 1", rsv_ready); end
    tick(); rsv_addr = 3'd3; #1;
    n_cmp++; if (pending !== 4'd7 || busy_vec !== 8'hFE) begin n_fail++; $display("[TB] FAIL fill_r0_noop: got %0d/%h want 7/FE", pending, busy_vec); end
    n_cmp++; if (rsv_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL fill_ready_held: got %b want 0", rsv_ready); end
    tick(); idle(); #1;
    n_cmp++; if (pending !== 4'd7) begin n_fail++; $display("[TB] FAIL fill_ignored: got %0d want 7", pending); end
    for (int i = 1; i < NR; i++) begin
      we3 = 1; wa3 = AW'(i); wd3 = DW'($urandom); tick();
    end
    idle(); #1;
    n_cmp++; if (pending !== 4'd0) begin n_fail++; $display("[TB] FAIL fill_drain: got %0d want 0", pending); end
  endtask

  task automatic test_bypass();
    logic [DW-1:0] exp_rd;
    logic          exp_bsy;
    we3 = 1; wa3 = 3'd2; wd3 = 8'h77; tick(); idle();
    rsv_valid = 1; rsv_addr = 3'd2; tick(); idle();
    ra1 = 3'd2; we3 = 1; wa3 = 3'd2; wd3 = 8'h3C; #1;
`ifdef RF_BYPASS_EN
    exp_rd = 8'h3C; exp_bsy = 1'b0;
`else
    exp_rd = 8'h77; exp_bsy = 1'b1;
`endif
    n_cmp++; if (rd1 !== exp_rd) begin n_fail++; $display("[TB] FAIL bypass_rd1: got %h want %h", rd1, exp_rd); end
    n_cmp++; if (busy1 !== exp_bsy) begin n_fail++; $display("[TB] FAIL bypass_busy1: got %b want %b", busy1, exp_bsy); end
    tick(); idle(); #1;
    n_cmp++; if (rd1 !== 8'h3C || busy1 !== 1'b0) begin n_fail++; $display("[TB] FAIL bypass_after: got %h/%b want 3C/0", rd1, busy1); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst       = ($urandom_range(99) < 2) ? 1'b0 : 1'b1;
      we3       = 1'($urandom_range(1));
      wa3       = AW'($urandom);
      wd3       = DW'($urandom);
      ra1       = AW'($urandom);
      ra2       = ($urandom_range(3) == 0) ? ra1 : AW'($urandom);
      rsv_valid = ($urandom_range(2) != 0);
      rsv_addr  = ($urandom_range(3) == 0) ? wa3 : AW'($urandom);
      #1;
      n_cmp++; if (rd1 !== m_rd(ra1) || rd2 !== m_rd(ra2)) begin n_fail++; $display("[TB] FAIL rand_rd: got %h/%h want %h/%h", rd1, rd2, m_rd(ra1), m_rd(ra2)); end
      n_cmp++; if (busy1 !== m_bsy(ra1) || busy2 !== m_bsy(ra2)) begin n_fail++; $display("[TB] FAIL rand_busy: got %b/%b want %b/%b", busy1, busy2, m_bsy(ra1), m_bsy(ra2)); end
      n_cmp++; if (rsv_ready !== m_ready()) begin n_fail++; $display("[TB] FAIL rand_ready: got %b want %b", rsv_ready, m_ready()); end
      n_cmp++; if (busy_vec !== m_vec() || int'(pending) != m_pend()) begin n_fail++; $display("[TB] FAIL rand_sb: got %h/%0d want %h/%0d", busy_vec, pending, m_vec(), m_pend()); end
      tick();
    end
    rst = 1; idle();
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin m_reg[i] = '0; m_busy[i] = 0; end
    rst = 0;
    tick();
    tick();
    rst = 1;
    test_reset();
    test_basic();
    test_scoreboard();
    test_simultaneous();
    test_fill();
    test_bypass();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
